// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle core: the muldiv operation encoding
// (RV32M funct3) and the muldiv sequencer states.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_SPECIAL
  } muldiv_state_t;

endpackage

// File: rtl/cpu_div_step.sv
// Combinational restoring divide step: retires STEP quotient bits, shifting
// dividend bits out of the quotient register into the partial remainder.
module cpu_div_step #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_quo;
  logic [XLEN:0]   w_trial;

  always_comb begin
    w_rem   = i_rem;
    w_quo   = i_quo;
    w_trial = '0;
    for (int i = 0; i < STEP; i++) begin
      // Partial remainder stays below the divisor, so XLEN+1 bits suffice.
      w_trial = {w_rem, w_quo[XLEN-1]};
      w_quo   = {w_quo[XLEN-2:0], 1'b0};
      if (w_trial >= {1'b0, i_div}) begin
        w_trial  = w_trial - {1'b0, i_div};
        w_quo[0] = 1'b1;
      end
      w_rem = w_trial[XLEN-1:0];
    end
  end

  assign o_rem = w_rem;
  assign o_quo = w_quo;

endmodule

// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit: magnitude datapath with sign fix-up,
// STEP bits per cycle, start/ready/done handshake with abort.
module cpu_muldiv
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            abort_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);

  // Handshake: start_i is taken on an edge with ready_o=1 and abort_i=0;
  // done_o is a one-cycle pulse with res_o valid and ready_o already high.
  muldiv_state_t     r_state;
  muldiv_op_t        r_op;
  logic              r_is_div;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_done;
  logic [XLEN-1:0]   r_res;

  muldiv_op_t      w_op;
  logic            w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
  logic            w_div0, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;

  assign w_op     = muldiv_op_t'(op_i);
  assign w_is_div = op_i[2];
  assign w_a_sgn  = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                    (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_sgn  = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                    (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg  = w_a_sgn & src_a_i[XLEN-1];
  assign w_b_neg  = w_b_sgn & src_b_i[XLEN-1];
  assign w_a_mag  = w_a_neg ? -src_a_i : src_a_i;
  assign w_b_mag  = w_b_neg ? -src_b_i : src_b_i;
  // Remainder takes the dividend's sign; everything else the product of signs.
  assign w_neg    = (w_is_div && op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0   = w_is_div && (src_b_i == '0);
  assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                    (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
  assign w_spec_res = w_div0 ? (op_i[1] ? src_a_i : '1)
                             : (op_i[1] ? '0 : src_a_i);

  // Shift-add: add STEP-bit multiple of the multiplicand to the high half,
  // then shift the whole accumulator right by STEP.
  logic [XLEN+STEP-1:0] w_mul_sum;
  logic [2*XLEN-1:0]    w_mul_next;
  assign w_mul_sum  = {{STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} +
                      (XLEN+STEP)'(r_b) * (XLEN+STEP)'(r_acc[STEP-1:0]);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:STEP]};

  logic [XLEN-1:0] w_div_rem, w_div_quo;

  cpu_div_step #(.XLEN(XLEN), .STEP(STEP)) u_div_step (
    .i_rem (r_acc[2*XLEN-1:XLEN]),
    .i_quo (r_acc[XLEN-1:0]),
    .i_div (r_b),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fix_res;
  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_quo_fix = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_fix = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quo_fix;
      default:                      w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_done   <= 1'b0;
      r_res    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            r_op     <= w_op;
            r_is_div <= w_is_div;
            r_neg    <= w_neg;
            r_b      <= w_b_mag;
            if (w_div0 || w_ovf) begin
              r_acc   <= {{XLEN{1'b0}}, w_spec_res};
              r_state <= ST_SPECIAL;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, w_a_mag};
              r_cnt   <= CW'(N);
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= r_is_div ? {w_div_rem, w_div_quo} : w_mul_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!abort_i) begin
            r_res  <= w_fix_res;
            r_done <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        ST_SPECIAL: begin
          if (!abort_i) begin
            r_res  <= r_acc[XLEN-1:0];
            r_done <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == ST_IDLE);
  assign done_o  = r_done;
  assign res_o   = r_res;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Directed bench for cpu_muldiv: STEP=1 and STEP=4 instances side by side,
// hand-computed RV32M results, latency, abort and reset behaviour.
module tb_cpu_muldiv;

  int checks   = 0;
  int failures = 0;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  logic [1:0]       start_s = '0;
  logic [1:0]       abort_s = '0;
  logic [1:0][2:0]  op_s    = '0;
  logic [1:0][31:0] a_s     = '0;
  logic [1:0][31:0] b_s     = '0;

  logic        ready_0, ready_1, done_0, done_1;
  logic [31:0] res_0, res_1;

  always #5 clk = ~clk;

  cpu_muldiv #(.XLEN(32), .STEP(1)) u_step1 (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .start_i (start_s[0]),
    .op_i    (op_s[0]),
    .src_a_i (a_s[0]),
    .src_b_i (b_s[0]),
    .abort_i (abort_s[0]),
    .ready_o (ready_0),
    .done_o  (done_0),
    .res_o   (res_0)
  );

  cpu_muldiv #(.XLEN(32), .STEP(4)) u_step4 (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .start_i (start_s[1]),
    .op_i    (op_s[1]),
    .src_a_i (a_s[1]),
    .src_b_i (b_s[1]),
    .abort_i (abort_s[1]),
    .ready_o (ready_1),
    .done_o  (done_1),
    .res_o   (res_1)
  );

  // Normal ops: done_o is sampled high N+1 edges after the accept edge.
  localparam int NV = 10;
  localparam logic [2:0]  V_OP  [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                                         3'd6, 3'd5, 3'd7, 3'd0, 3'd4};
  localparam logic [31:0] V_A   [NV] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                         32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                         32'h1234_5678, 32'd7};
  localparam logic [31:0] V_B   [NV] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                                         32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2,
                                         32'h10, 32'hFFFF_FFFE};
  localparam logic [31:0] V_EXP [NV] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF,
                                         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                         32'd3, 32'd1, 32'h2345_6780, 32'hFFFF_FFFD};

  // Divide-by-zero and signed overflow: done_o one edge after accept.
  localparam int NS = 6;
  localparam logic [2:0]  S_OP  [NS] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  localparam logic [31:0] S_A   [NS] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                         32'hFFFF_FFF9, 32'hFFFF_FFF9};
  localparam logic [31:0] S_B   [NS] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                         32'd0, 32'd0};
  localparam logic [31:0] S_EXP [NS] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                         32'hFFFF_FFFF, 32'hFFFF_FFF9};

  function automatic logic get_done(input int u);
    return (u == 0) ? done_0 : done_1;
  endfunction

  function automatic logic get_ready(input int u);
    return (u == 0) ? ready_0 : ready_1;
  endfunction

  function automatic logic [31:0] get_res(input int u);
    return (u == 0) ? res_0 : res_1;
  endfunction

  // Issues one operation, scrambles operands after accept, and returns the
  // result, the edge count from accept to done, and done one cycle later.
  task automatic do_op(input int u, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output int lat, output logic dbl);
    @(negedge clk);
    start_s[u] = 1'b1;
    op_s[u]    = op;
    a_s[u]     = a;
    b_s[u]     = b;
    @(posedge clk);
    #1;
    start_s[u] = 1'b0;
    op_s[u]    = 3'($urandom_range(0, 7));
    a_s[u]     = $urandom;
    b_s[u]     = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!get_done(u) && lat < 100);
    res = get_res(u);
    @(posedge clk);
    #1;
    dbl = get_done(u);
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_0 !== 1'b1 || ready_1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b%b expected 11", ready_0, ready_1);
    end
    checks++;
    if (done_0 !== 1'b0 || done_1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b%b expected 00", done_0, done_1);
    end
    checks++;
    if (res_0 !== 32'd0 || res_1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_res: got %h %h expected 0", res_0, res_1);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_normal(input int u);
    logic [31:0] res;
    int          lat;
    logic        dbl;
    int          exp_lat;
    exp_lat = 32 / ((u == 0) ? 1 : 4) + 1;
    for (int i = 0; i < NV; i++) begin
      do_op(u, V_OP[i], V_A[i], V_B[i], res, lat, dbl);
      checks++;
      if (res !== V_EXP[i]) begin
        failures++;
        $display("FAIL vec%0d_res u%0d: got %h expected %h", i, u, res, V_EXP[i]);
      end
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL vec%0d_latency u%0d: got %0d expected %0d", i, u, lat, exp_lat);
      end
      checks++;
      if (dbl !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_single_pulse u%0d: got %b expected 0", i, u, dbl);
      end
    end
  endtask

  task automatic test_special(input int u);
    logic [31:0] res;
    int          lat;
    logic        dbl;
    for (int i = 0; i < NS; i++) begin
      do_op(u, S_OP[i], S_A[i], S_B[i], res, lat, dbl);
      checks++;
      if (res !== S_EXP[i]) begin
        failures++;
        $display("FAIL special%0d_res u%0d: got %h expected %h", i, u, res, S_EXP[i]);
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL special%0d_latency u%0d: got %0d expected 1", i, u, lat);
      end
      checks++;
      if (dbl !== 1'b0) begin
        failures++;
        $display("FAIL special%0d_single_pulse u%0d: got %b expected 0", i, u, dbl);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int          lat;
    logic        dbl;
    int          dones;
    do_op(0, 3'd0, 32'd3, 32'd5, res, lat, dbl);
    checks++;
    if (res !== 32'd15) begin
      failures++;
      $display("FAIL abort_setup_res: got %h expected 0000000f", res);
    end
    @(negedge clk);
    start_s[0] = 1'b1;
    op_s[0]    = 3'd0;
    a_s[0]     = 32'h1234;
    b_s[0]     = 32'h5678;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ready_0 !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy_ready: got %b expected 0", ready_0);
    end
    abort_s[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_s[0] = 1'b0;
    checks++;
    if (ready_0 !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready: got %b expected 1", ready_0);
    end
    dones = 0;
    repeat (40) begin
      if (done_0) dones++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", dones);
    end
    checks++;
    if (res_0 !== 32'd15) begin
      failures++;
      $display("FAIL abort_res_held: got %h expected 0000000f", res_0);
    end
    // Abort in IDLE wins over a simultaneous start.
    @(negedge clk);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    op_s[0]    = 3'd0;
    a_s[0]     = 32'd2;
    b_s[0]     = 32'd2;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    checks++;
    if (ready_0 !== 1'b1) begin
      failures++;
      $display("FAIL idle_abort_ready: got %b expected 1", ready_0);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_0) dones++;
    end
    checks++;
    if (dones !== 0 || res_0 !== 32'd15) begin
      failures++;
      $display("FAIL idle_abort_ignored: got %0d pulses res %h expected 0 pulses res 0000000f",
               dones, res_0);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    start_s[0] = 1'b1;
    op_s[0]    = 3'd4;
    a_s[0]     = 32'hFFFF_FFF9;
    b_s[0]     = 32'd2;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (ready_0 !== 1'b1 || done_0 !== 1'b0 || res_0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got ready=%b done=%b res=%h expected 1 0 00000000",
               ready_0, done_0, res_0);
    end
    @(negedge clk);
    rstn = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_0) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start_s[1] = 1'b1;
    op_s[1]    = 3'd0;
    a_s[1]     = 32'd7;
    b_s[1]     = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!done_1 && lat < 100);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL b2b_first_latency: got %0d expected 9", lat);
    end
    checks++;
    if (ready_1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_with_done: got %b expected 1", ready_1);
    end
    checks++;
    if (res_1 !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL b2b_first_res: got %h expected ffffffeb", res_1);
    end
    start_s[1] = 1'b1;
    op_s[1]    = 3'd5;
    a_s[1]     = 32'd7;
    b_s[1]     = 32'd2;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    checks++;
    if (done_1 !== 1'b0 || ready_1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accepted: got done=%b ready=%b expected 0 0", done_1, ready_1);
    end
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!done_1 && lat < 100);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d expected 9", lat);
    end
    checks++;
    if (res_1 !== 32'd3) begin
      failures++;
      $display("FAIL b2b_second_res: got %h expected 00000003", res_1);
    end
  endtask

  initial begin
    test_reset();
    test_normal(0);
    test_normal(1);
    test_special(0);
    test_special(1);
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
